// File: rtl/mig_app_model_pkg.sv
// Shared constants for the DDR4 MIG app-interface behavioural model.
// Command encodings match the MIG app_cmd field.
package mig_app_model_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_model_fifo.sv
// Synchronous FIFO used for the write-command and write-data queues.
// DEPTH must be a power of two (>= 2); push is ignored when full, pop when empty.
module mig_model_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mig_app_model.sv
// Behavioural model of the DDR4 MIG app interface: calibration delay, decoupled
// write queues, fixed read latency, periodic back-pressure and read-after-write ordering.
module mig_app_model
  import mig_app_model_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 28,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int RD_LATENCY     = 8,
  parameter int WQ_DEPTH       = 4,
  parameter int STALL_PERIOD   = 0,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                    c0_ddr4_ui_clk,
  input  logic                    c0_ddr4_ui_clk_sync_rst,
  output logic                    c0_init_calib_complete,
  input  logic [ADDR_WIDTH-1:0]   c0_ddr4_app_addr,
  input  logic [2:0]              c0_ddr4_app_cmd,
  input  logic                    c0_ddr4_app_en,
  output logic                    c0_ddr4_app_rdy,
  input  logic [DATA_WIDTH-1:0]   c0_ddr4_app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] c0_ddr4_app_wdf_mask,
  input  logic                    c0_ddr4_app_wdf_wren,
  input  logic                    c0_ddr4_app_wdf_end,
  output logic                    c0_ddr4_app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   c0_ddr4_app_rd_data,
  output logic                    c0_ddr4_app_rd_data_valid,
  output logic                    c0_ddr4_app_rd_data_end
);

  localparam int MW    = DATA_WIDTH / 8;
  localparam int WORDS = 1 << MEM_WORDS_LOG2;
  localparam int CW    = $clog2(CALIB_CYCLES + 2);
  localparam int SP    = (STALL_PERIOD > 1) ? STALL_PERIOD : 2;
  localparam int SW    = $clog2(SP);

  logic                      clk, rst;
  logic [CW-1:0]             cal_cnt_q, cal_cnt_d;
  logic                      calib_q, calib_d;
  logic [SW-1:0]             stall_cnt_q, stall_cnt_d;
  logic                      stall;
  logic                      cmd_ok, accept, wr_push, rd_acc, wdf_push, commit;
  logic [MEM_WORDS_LOG2-1:0] word_idx, cm_idx;
  logic [DATA_WIDTH-1:0]     cm_data;
  logic [MW-1:0]             cm_mask;
  logic                      cq_full, cq_empty, dq_full, dq_empty;
  logic [DATA_WIDTH-1:0]     mem_q [WORDS];
  logic [RD_LATENCY-1:0]     rd_vld_q;
  logic [DATA_WIDTH-1:0]     rd_pipe_q [RD_LATENCY];
  logic                      unused_bits;

  assign clk         = c0_ddr4_ui_clk;
  assign rst         = c0_ddr4_ui_clk_sync_rst;
  assign word_idx    = c0_ddr4_app_addr[MEM_WORDS_LOG2+2:3];
  assign unused_bits = ^{c0_ddr4_app_wdf_end, c0_ddr4_app_addr[2:0],
                         c0_ddr4_app_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2+3]};

  // Calibration counter freezes once complete; stall counter only runs afterwards.
  always_comb begin
    cal_cnt_d   = cal_cnt_q;
    calib_d     = calib_q;
    stall_cnt_d = stall_cnt_q;
    if (!calib_q) begin
      cal_cnt_d = cal_cnt_q + CW'(1);
      if (cal_cnt_q == CW'(CALIB_CYCLES)) calib_d = 1'b1;
    end else begin
      stall_cnt_d = (stall_cnt_q == SW'(SP - 1)) ? '0 : stall_cnt_q + SW'(1);
    end
  end

  assign stall = (STALL_PERIOD > 1) && (stall_cnt_q == SW'(SP - 1));

  // Reads wait for every queued write command to commit, giving read-after-write order.
  always_comb begin
    cmd_ok = 1'b1;
    if (c0_ddr4_app_cmd == CMD_WRITE)     cmd_ok = ~cq_full;
    else if (c0_ddr4_app_cmd == CMD_READ) cmd_ok = cq_empty;
    c0_ddr4_app_rdy = calib_q & ~stall & cmd_ok;
  end

  assign accept              = c0_ddr4_app_en & c0_ddr4_app_rdy;
  assign wr_push             = accept & (c0_ddr4_app_cmd == CMD_WRITE);
  assign rd_acc              = accept & (c0_ddr4_app_cmd == CMD_READ);
  assign c0_ddr4_app_wdf_rdy = calib_q & ~dq_full;
  assign wdf_push            = c0_ddr4_app_wdf_wren & c0_ddr4_app_wdf_rdy;
  assign commit              = ~rst & ~cq_empty & ~dq_empty;

  mig_model_fifo #(.WIDTH(MEM_WORDS_LOG2), .DEPTH(WQ_DEPTH)) u_cmd_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wr_push),
    .din_i   (word_idx),
    .pop_i   (commit),
    .dout_o  (cm_idx),
    .full_o  (cq_full),
    .empty_o (cq_empty)
  );

  mig_model_fifo #(.WIDTH(DATA_WIDTH + MW), .DEPTH(WQ_DEPTH)) u_data_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wdf_push),
    .din_i   ({c0_ddr4_app_wdf_mask, c0_ddr4_app_wdf_data}),
    .pop_i   (commit),
    .dout_o  ({cm_mask, cm_data}),
    .full_o  (dq_full),
    .empty_o (dq_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cal_cnt_q   <= '0;
      calib_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cal_cnt_q   <= cal_cnt_d;
      calib_q     <= calib_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Array contents survive reset so data written before a reset can be read back.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < MW; b++) begin
        if (!cm_mask[b]) mem_q[cm_idx][b*8 +: 8] <= cm_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_vld_q[0]  <= rd_acc;
      rd_pipe_q[0] <= rd_acc ? mem_q[word_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  assign c0_init_calib_complete    = calib_q;
  assign c0_ddr4_app_rd_data       = rd_pipe_q[RD_LATENCY-1];
  assign c0_ddr4_app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign c0_ddr4_app_rd_data_end   = rd_vld_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_model.sv
// Directed testbench for mig_app_model: calibration timing, write/read ordering,
// masking, queue back-pressure, periodic stalls and reset with reads in flight.
module tb_mig_app_model;

  localparam int DW  = 512;
  localparam int AW  = 28;
  localparam int MWL = 12;
  localparam int RL  = 8;
  localparam int WQ  = 4;
  localparam int SP  = 4;
  localparam int CC  = 16;
  localparam int MW  = DW / 8;
  localparam logic [2:0] C_WR = 3'b000;
  localparam logic [2:0] C_RD = 3'b001;
  localparam logic [2:0] C_NOP = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] wdf_data;
  logic [MW-1:0] wdf_mask;
  logic          wdf_wren, wdf_end, wdf_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_end;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int calib_edge = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_d[$];
  int            obs_c[$];
  logic          obs_e[$];
  int            acc_q[$];
  logic          rdy_obs[$];
  int            rdy_cyc[$];

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mig_app_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS_LOG2(MWL), .RD_LATENCY(RL),
    .WQ_DEPTH(WQ), .STALL_PERIOD(SP), .CALIB_CYCLES(CC)
  ) dut (
    .c0_ddr4_ui_clk            (clk),
    .c0_ddr4_ui_clk_sync_rst   (rst),
    .c0_init_calib_complete    (calib),
    .c0_ddr4_app_addr          (app_addr),
    .c0_ddr4_app_cmd           (app_cmd),
    .c0_ddr4_app_en            (app_en),
    .c0_ddr4_app_rdy           (app_rdy),
    .c0_ddr4_app_wdf_data      (wdf_data),
    .c0_ddr4_app_wdf_mask      (wdf_mask),
    .c0_ddr4_app_wdf_wren      (wdf_wren),
    .c0_ddr4_app_wdf_end       (wdf_end),
    .c0_ddr4_app_wdf_rdy       (wdf_rdy),
    .c0_ddr4_app_rd_data       (rd_data),
    .c0_ddr4_app_rd_data_valid (rd_valid),
    .c0_ddr4_app_rd_data_end   (rd_end)
  );

  // Read-return monitor: records every strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (rd_valid) begin
      obs_d.push_back(rd_data);
      obs_c.push_back(cyc);
      obs_e.push_back(rd_end);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Driver tasks: all return at posedge+1 so the next drive is race-free
  task automatic issue_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, output int acc);
    app_cmd = cmd; app_addr = addr; app_en = 1'b1; acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (app_rdy) begin acc = cyc + 1; break; end
    end
    @(posedge clk); #1;
    app_en = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL cmd_handshake: app_rdy never high, cmd=%0d addr=%h", cmd, addr);
    end
  endtask

  task automatic issue_data(input logic [DW-1:0] d, input logic [MW-1:0] m, output int acc);
    wdf_data = d; wdf_mask = m; wdf_wren = 1'b1; wdf_end = 1'b1; acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wdf_rdy) begin acc = cyc + 1; break; end
    end
    @(posedge clk); #1;
    wdf_wren = 1'b0; wdf_end = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL data_handshake: wdf_rdy never high");
    end
  endtask

  task automatic stream_reads(input int n, input logic [AW-1:0] base);
    int k;
    k = 0;
    acc_q.delete(); rdy_obs.delete(); rdy_cyc.delete();
    app_cmd = C_RD; app_addr = base; app_en = 1'b1;
    for (int i = 0; i < 200 && k < n; i++) begin
      @(negedge clk);
      rdy_obs.push_back(app_rdy);
      rdy_cyc.push_back(cyc);
      if (app_rdy) begin acc_q.push_back(cyc + 1); k++; end
      @(posedge clk); #1;
      app_addr = base + AW'(8 * k);
      if (k == n) app_en = 1'b0;
    end
    app_en = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL stream_reads: accepted %0d of %0d reads", k, n);
    end
  endtask

  task automatic get_rd(output logic [DW-1:0] d, output int c, output logic e, output bit ok);
    ok = 1'b0; d = '0; c = -1; e = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (obs_d.size() > 0) begin
        d = obs_d.pop_front(); c = obs_c.pop_front(); e = obs_e.pop_front(); ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_calib(input string tag);
    for (int k = 1; k <= CC + 1; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == CC) begin
        checks++;
        if (calib !== 1'b0 || app_rdy !== 1'b0 || wdf_rdy !== 1'b0) begin
          errors++;
          $display("FAIL %s_pre_calib: calib=%b app_rdy=%b wdf_rdy=%b, need 0 0 0", tag, calib, app_rdy, wdf_rdy);
        end
      end
      if (k == CC + 1) begin
        checks++;
        if (calib !== 1'b1) begin
          errors++;
          $display("FAIL %s_calib_edge: calib=%b at clock %0d after release, need 1", tag, calib, k);
        end
        calib_edge = cyc;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    app_en = 1'b0; app_cmd = C_NOP; app_addr = '0;
    wdf_wren = 1'b0; wdf_end = 1'b0; wdf_data = '0; wdf_mask = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({calib, app_rdy, wdf_rdy, rd_valid, rd_end} !== 5'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: calib/rdy/wdf_rdy/valid/end=%b%b%b%b%b, need 00000",
               calib, app_rdy, wdf_rdy, rd_valid, rd_end);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_calib("reset");
    // Now at calib_edge+1; stall count is 3 in the cycle after edge calib_edge+3
    @(negedge clk);
    checks++;
    if (app_rdy !== 1'b1 || wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_calib: app_rdy=%b wdf_rdy=%b, need 1 1", app_rdy, wdf_rdy);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (app_rdy !== 1'b0 || wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL first_stall: app_rdy=%b wdf_rdy=%b at cycle %0d, need 0 1", app_rdy, wdf_rdy, cyc - calib_edge);
    end
    @(negedge clk);
    checks++;
    if (app_rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_stall: app_rdy=%b, need 1", app_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a1, a2, ar, c;
    logic [DW-1:0] d, wd;
    logic e;
    bit ok;
    wd = {64{8'hA5}};
    fork
      issue_cmd(C_WR, 28'h40, a1);
      issue_data(wd, '0, a2);
    join
    issue_cmd(C_RD, 28'h40, ar);
    get_rd(d, c, e, ok);
    checks++;
    if (!ok || d !== wd) begin
      errors++;
      $display("FAIL wr_rd_data: got %h need %h (seen=%0d)", d, wd, ok);
    end
    checks++;
    if (c != ar + RL - 1) begin
      errors++;
      $display("FAIL wr_rd_latency: valid seen at %0d, need %0d", c, ar + RL - 1);
    end
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_end: rd_data_end=%b with valid, need 1", e);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_d.size() != 0 || rd_valid !== 1'b0 || rd_end !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_single_pulse: extra strobes=%0d valid=%b end=%b, need 0 0 0", obs_d.size(), rd_valid, rd_end);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_data_first_masked();
    int a1, a2, ad, ac, ar, c;
    logic [DW-1:0] d, d1, d2, ex;
    logic [MW-1:0] m;
    logic e;
    bit ok;
    d1 = {64{8'h3C}};
    d2 = {64{8'h96}};
    m = '1; m[0] = 1'b0;
    fork
      issue_cmd(C_WR, 28'h100, a1);
      issue_data(d1, '0, a2);
    join
    issue_data(d2, m, ad);
    repeat (3) @(posedge clk);
    #1;
    issue_cmd(C_WR, 28'h100, ac);
    // bit 15 sits above the word index and bits [2:0] are ignored: same word
    issue_cmd(C_RD, 28'h0008105, ar);
    ex = {d1[DW-1:8], 8'h96};
    get_rd(d, c, e, ok);
    checks++;
    if (!ok || d !== ex) begin
      errors++;
      $display("FAIL masked_alias_data: got %h need %h", d, ex);
    end
    checks++;
    if (c != ar + RL - 1) begin
      errors++;
      $display("FAIL masked_alias_latency: valid at %0d, need %0d", c, ar + RL - 1);
    end
  endtask

  task automatic test_queue_full();
    int a, ar, ad, last, c;
    logic [DW-1:0] d, ex;
    logic [31:0] w;
    logic e;
    bit ok;
    last = -1; ex = '0;
    for (int i = 0; i < WQ; i++) issue_cmd(C_WR, 28'h80, a);
    app_cmd = C_WR; app_addr = 28'h80; app_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (app_rdy !== 1'b0) begin
        errors++;
        $display("FAIL fifth_write_held: app_rdy=%b with full command queue, need 0", app_rdy);
      end
    end
    @(posedge clk); #1;
    app_cmd = C_RD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (app_rdy !== 1'b0) begin
        errors++;
        $display("FAIL read_blocked: app_rdy=%b with pending writes, need 0", app_rdy);
      end
    end
    @(posedge clk); #1;
    w = 32'h5A5A0003;
    ex = {16{w}};
    fork
      issue_cmd(C_RD, 28'h80, ar);
      begin
        for (int j = 0; j < WQ; j++) begin
          logic [31:0] wj;
          wj = 32'h5A5A0000 + 32'(j);
          issue_data({16{wj}}, '0, ad);
          last = ad;
        end
      end
    join
    checks++;
    if (ar < last + 2) begin
      errors++;
      $display("FAIL read_after_commit: read accepted at %0d, last data at %0d, need >= %0d", ar, last, last + 2);
    end
    get_rd(d, c, e, ok);
    checks++;
    if (!ok || d !== ex) begin
      errors++;
      $display("FAIL queue_full_latest: got %h need %h", d, ex);
    end
  endtask

  task automatic test_back_to_back_stall();
    int a1, a2, c, n;
    logic [DW-1:0] d, ex;
    logic [31:0] w;
    logic e, er;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      w = 32'hC0DE0000 + 32'(i);
      fork
        issue_cmd(C_WR, 28'h200 + AW'(8 * i), a1);
        issue_data({16{w}}, '0, a2);
      join
      exp_q.push_back({16{w}});
    end
    repeat (4) @(posedge clk);
    #1;
    stream_reads(6, 28'h200);
    n = rdy_obs.size();
    for (int i = 0; i < n; i++) begin
      er = (((rdy_cyc[i] - calib_edge) % SP) != SP - 1);
      checks++;
      if (rdy_obs[i] !== er) begin
        errors++;
        $display("FAIL stall_pattern: app_rdy=%b at cycle %0d after calib, need %b", rdy_obs[i], rdy_cyc[i] - calib_edge, er);
      end
    end
    for (int i = 0; i < 6; i++) begin
      get_rd(d, c, e, ok);
      ex = exp_q.pop_front();
      checks++;
      if (!ok || d !== ex || c != acc_q[i] + RL - 1) begin
        errors++;
        $display("FAIL b2b_read%0d: data %h at %0d, need %h at %0d", i, d, c, ex, acc_q[i] + RL - 1);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int ar, c;
    logic [DW-1:0] d, ex;
    logic e;
    bit ok;
    ex = {64{8'hA5}};
    stream_reads(3, 28'h200);
    rst = 1'b1;
    checks++;
    if (obs_d.size() != 0) begin
      errors++;
      $display("FAIL inflight_before_reset: %0d strobes already returned, need 0", obs_d.size());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_calib("rerst");
    repeat (RL + 2) @(posedge clk);
    #1;
    checks++;
    if (obs_d.size() != 0) begin
      errors++;
      $display("FAIL reset_drops_reads: %0d strobes after reset, need 0", obs_d.size());
    end
    issue_cmd(C_RD, 28'h40, ar);
    get_rd(d, c, e, ok);
    checks++;
    if (!ok || d !== ex) begin
      errors++;
      $display("FAIL mem_survives_reset: got %h need %h", d, ex);
    end
    checks++;
    if (c != ar + RL - 1) begin
      errors++;
      $display("FAIL post_reset_latency: valid at %0d, need %0d", c, ar + RL - 1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_data_first_masked();
    test_queue_full();
    test_back_to_back_stall();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
